mips_multicycle_ctrl: RTL and testbench

Main control FSM for the multicycle MIPS datapath. Decodes the 6-bit opcode latched in the IR and sequences the datapath through fetch, decode, execute, memory and writeback. Produces every datapath enable and mux select, including the 2-bit `alu_ct_op` consumed by the ALU control decoder. Stalls on a single-port memory ready handshake.

---
 rtl/mips_pkg.sv | 47 ++++
 rtl/mips_multicycle_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control path: opcodes, mux encodings, FSM states.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package mips_pkg;

    // Supported opcodes (IR[31:26])
    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_J     = 6'b000010;
    localparam logic [5:0] OPC_ADDIU = 6'b001001;

    // alu_ct_op: request to the ALU control decoder
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // alu_src_b: ALU B operand select
    localparam logic [1:0] ALUB_REG     = 2'b00;
    localparam logic [1:0] ALUB_FOUR    = 2'b01;
    localparam logic [1:0] ALUB_IMM     = 2'b10;
    localparam logic [1:0] ALUB_IMM_SL2 = 2'b11;

    // pc_source: next-PC select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Main control FSM states; encodings are visible on state_dbg
    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_EXECUTE   = 4'd6,
        S_ALU_WB    = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EX   = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_TRAP      = 4'd12
    } ctrl_state_t;

endpackage

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS datapath: decodes the IR opcode and drives all enables/selects.
// Latency: outputs are Moore decodes of the state register; fetch ir/pc write and sw completion gated by mem_ready.
// Backpressure: FETCH, MEM_READ and MEM_WRITE hold (requests stable) until mem_ready=1.
module mips_multicycle_ctrl
    import mips_pkg::*;
#(
    parameter logic [5:0] OP_RTYPE = OPC_RTYPE,
    parameter logic [5:0] OP_LW    = OPC_LW,
    parameter logic [5:0] OP_SW    = OPC_SW,
    parameter logic [5:0] OP_BEQ   = OPC_BEQ,
    parameter logic [5:0] OP_J     = OPC_J,
    parameter logic [5:0] OP_ADDIU = OPC_ADDIU
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_ct_op,
    output logic [1:0] pc_source,
    output logic       instr_done,
    output logic       illegal_op,
    output logic [3:0] state_dbg
);

    ctrl_state_t state_q, state_d;
    logic        illegal_q;

    // State register; reset lands in FETCH regardless of any pending stall
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Sticky illegal-opcode flag, set on the edge that enters TRAP so it is high for all of TRAP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            illegal_q <= 1'b0;
        end else if (state_d == S_TRAP) begin
            illegal_q <= 1'b1;
        end
    end

    // Next-state and datapath control decode; every output defaults to its idle value first
    always_comb begin
        state_d       = state_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_write     = 1'b0;
        reg_dst       = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = ALUB_REG;
        alu_ct_op     = ALUOP_ADD;
        pc_source     = PCSRC_ALU;
        instr_done    = 1'b0;

        case (state_q)
            S_FETCH: begin
                // PC+4 is computed every cycle; it and the IR only commit once memory answers
                mem_read  = 1'b1;
                alu_src_b = ALUB_FOUR;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                // Speculatively form the branch target into ALUOut while decoding
                alu_src_b = ALUB_IMM_SL2;
                if (opcode == OP_LW || opcode == OP_SW) begin
                    state_d = S_MEM_ADDR;
                end else if (opcode == OP_RTYPE) begin
                    state_d = S_EXECUTE;
                end else if (opcode == OP_BEQ) begin
                    state_d = S_BRANCH;
                end else if (opcode == OP_J) begin
                    state_d = S_JUMP;
                end else if (opcode == OP_ADDIU) begin
                    state_d = S_ADDI_EX;
                end else begin
                    state_d = S_TRAP;
                end
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUB_IMM;
                state_d   = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            end
            S_MEM_READ: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) begin
                    state_d = S_MEM_WB;
                end
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WRITE: begin
                // Store retires in the cycle memory accepts it, so done follows mem_ready
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) begin
                    instr_done = 1'b1;
                    state_d    = S_FETCH;
                end
            end
            S_EXECUTE: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUB_REG;
                alu_ct_op = ALUOP_FUNCT;
                state_d   = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = 1'b1;
                alu_src_b     = ALUB_REG;
                alu_ct_op     = ALUOP_SUB;
                pc_write_cond = 1'b1;
                pc_source     = PCSRC_ALUOUT;
                instr_done    = 1'b1;
                state_d       = S_FETCH;
            end
            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = PCSRC_JUMP;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_ADDI_EX: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUB_IMM;
                state_d   = S_ADDI_WB;
            end
            S_ADDI_WB: begin
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_d    = S_FETCH;
            end
            S_TRAP: begin
                // Dead end: only reset leaves TRAP
                state_d = S_TRAP;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    assign illegal_op = illegal_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: each instruction is modelled as a list of phases walked per cycle.
// Latency: outputs compared every cycle, #1 after the falling edge.
// Backpressure: mem_ready driven from fixed patterns or $urandom.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
    logic       mem_to_reg, reg_write, reg_dst, alu_src_a, instr_done, illegal_op;
    logic [1:0] alu_src_b, alu_ct_op, pc_source;
    logic [3:0] state_dbg;

    mips_multicycle_ctrl dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .reg_dst(reg_dst),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_ct_op(alu_ct_op),
        .pc_source(pc_source), .instr_done(instr_done), .illegal_op(illegal_op),
        .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    // Bit map: [21]pc_write [20]pc_write_cond [19]i_or_d [18]mem_read [17]mem_write [16]ir_write
    // [15]mem_to_reg [14]reg_write [13]reg_dst [12]alu_src_a [11:10]alu_src_b [9:8]alu_ct_op
    // [7:6]pc_source [5]instr_done [4]illegal_op [3:0]state_dbg
    logic [21:0] dut_vec;
    assign dut_vec = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                      mem_to_reg, reg_write, reg_dst, alu_src_a, alu_src_b, alu_ct_op,
                      pc_source, instr_done, illegal_op, state_dbg};

    int checks = 0;
    int errors = 0;

    // Model: the phases an instruction walks through, and where it currently is
    int          path[$];
    int          idx;
    bit          model_done;
    logic [21:0] obs[0:64];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Required outputs of each phase, straight from the per-phase output lists
    function automatic logic [21:0] exp_vec(input int ph, input logic rdy);
        logic pw, pwc, iod, mr, mw, irw, m2r, rw, rd, asa, dn, ill;
        logic [1:0] b, ct, ps;
        {pw, pwc, iod, mr, mw, irw, m2r, rw, rd, asa, dn, ill} = '0;
        b = 2'b00; ct = 2'b00; ps = 2'b00;
        case (ph)
            0:  begin mr = 1'b1; b = 2'b01; irw = rdy; pw = rdy; end
            1:  begin b = 2'b11; end
            2:  begin asa = 1'b1; b = 2'b10; end
            3:  begin mr = 1'b1; iod = 1'b1; end
            4:  begin rw = 1'b1; m2r = 1'b1; dn = 1'b1; end
            5:  begin mw = 1'b1; iod = 1'b1; dn = rdy; end
            6:  begin asa = 1'b1; ct = 2'b10; end
            7:  begin rw = 1'b1; rd = 1'b1; dn = 1'b1; end
            8:  begin asa = 1'b1; ct = 2'b01; pwc = 1'b1; ps = 2'b01; dn = 1'b1; end
            9:  begin pw = 1'b1; ps = 2'b10; dn = 1'b1; end
            10: begin asa = 1'b1; b = 2'b10; end
            11: begin rw = 1'b1; dn = 1'b1; end
            default: begin ill = 1'b1; end
        endcase
        return {pw, pwc, iod, mr, mw, irw, m2r, rw, rd, asa, b, ct, ps, dn, ill, 4'(ph)};
    endfunction

    task automatic build_path(input logic [5:0] op);
        path.delete();
        path.push_back(0);
        path.push_back(1);
        case (op)
            6'b100011: begin path.push_back(2); path.push_back(3); path.push_back(4); end
            6'b101011: begin path.push_back(2); path.push_back(5); end
            6'b000000: begin path.push_back(6); path.push_back(7); end
            6'b000100: path.push_back(8);
            6'b000010: path.push_back(9);
            6'b001001: begin path.push_back(10); path.push_back(11); end
            default:   path.push_back(12);
        endcase
        idx = 0;
        model_done = 1'b0;
    endtask

    // One clock of stimulus + compare; then the model moves on unless the phase waits on memory
    task automatic cycle(input logic rdy, input string tag, output logic [21:0] v);
        int ph;
        @(negedge clk);
        mem_ready = rdy;
        #1;
        v  = dut_vec;
        ph = path[idx];
        check(tag, 32'(v), 32'(exp_vec(ph, rdy)));
        if (ph == 12) begin
            // trapped: stays put
        end else if ((ph == 0 || ph == 3 || ph == 5) && !rdy) begin
            // waiting on memory
        end else if (idx == path.size() - 1) begin
            model_done = 1'b1;
        end else begin
            idx++;
        end
    endtask

    // Reset asserted mid-cycle, checked while held, released with mem_ready low so FETCH holds
    task automatic apply_reset(input logic rdy, output logic [21:0] v);
        @(negedge clk);
        mem_ready = rdy;
        rst = 1'b1;
        #1;
        v = dut_vec;
        check("reset_async", 32'(v), 32'(exp_vec(0, rdy)));
        @(negedge clk);
        rst = 1'b0;
        mem_ready = 1'b0;
        #1;
        check("reset_release", 32'(dut_vec), 32'(exp_vec(0, 1'b0)));
    endtask

    task automatic do_instr(input string tag, input logic [5:0] op, input logic [31:0] pat,
                            input bit use_pat, input int maxc, input int abort_at,
                            output int done_at);
        logic [21:0] v;
        logic        r;
        build_path(op);
        opcode  = op;
        done_at = 0;
        for (int c = 1; c <= maxc; c++) begin
            r = use_pat ? pat[c-1] : logic'($urandom_range(0, 3) != 0);
            if (c == abort_at) begin
                apply_reset(r, v);
                obs[c] = v;
                return;
            end
            cycle(r, tag, v);
            obs[c] = v;
            if (v[5] && done_at == 0) done_at = c;
            if (model_done) break;
        end
        if (!model_done && path[path.size()-1] != 12) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: instruction not retired within %0d cycles, required retire", tag, maxc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          d;
        int          n;
        logic [21:0] v;
        logic [5:0]  ops[6];
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b000010, 6'b001001};

        rst = 1'b1;
        mem_ready = 1'b0;
        opcode = 6'b000000;
        repeat (3) @(negedge clk);
        #1;
        check("reset_vec", 32'(dut_vec), 32'h0004_0400);
        @(negedge clk);
        rst = 1'b0;
        build_path(6'b000000);

        // lw, memory always ready: states 0..4, done only in cycle 5
        do_instr("lw", 6'b100011, 32'hFFFF_FFFF, 1'b1, 32, 0, d);
        check("lw_len", 32'(d), 32'd5);
        check("lw_states", {12'd0, obs[1][3:0], obs[2][3:0], obs[3][3:0], obs[4][3:0], obs[5][3:0]}, 32'h0001_234);
        check("lw_wb_regwrite", 32'(obs[5][14]), 32'd1);
        check("lw_wb_memtoreg", 32'(obs[5][15]), 32'd1);

        // sw with 3 stall cycles in MEM_WRITE: 7 cycles, mem_write/i_or_d held 4 cycles
        do_instr("sw", 6'b101011, 32'h0000_0047, 1'b1, 32, 0, d);
        check("sw_len", 32'(d), 32'd7);
        n = 0;
        for (int c = 1; c <= 7; c++) if (obs[c][17]) n++;
        check("sw_memwrite_cycles", 32'(n), 32'd4);
        n = 0;
        for (int c = 1; c <= 7; c++) if (obs[c][19]) n++;
        check("sw_iord_cycles", 32'(n), 32'd4);

        do_instr("rtype", 6'b000000, 32'hFFFF_FFFF, 1'b1, 32, 0, d);
        check("rtype_len", 32'(d), 32'd4);
        check("rtype_ctop", 32'(obs[3][9:8]), 32'd2);
        check("rtype_regdst", 32'(obs[4][13]), 32'd1);

        do_instr("beq", 6'b000100, 32'hFFFF_FFFF, 1'b1, 32, 0, d);
        check("beq_len", 32'(d), 32'd3);
        check("beq_ctl", {26'd0, obs[3][9:8], obs[3][20], obs[3][7:6], 1'b0}, {26'd0, 2'b01, 1'b1, 2'b01, 1'b0});

        do_instr("j", 6'b000010, 32'hFFFF_FFFF, 1'b1, 32, 0, d);
        check("j_len", 32'(d), 32'd3);
        check("j_ctl", {29'd0, obs[3][21], obs[3][7:6]}, {29'd0, 1'b1, 2'b10});

        do_instr("addiu", 6'b001001, 32'hFFFF_FFFF, 1'b1, 32, 0, d);
        check("addiu_len", 32'(d), 32'd4);
        check("addiu_srcb", 32'(obs[3][11:10]), 32'd2);
        check("addiu_wb", {30'd0, obs[4][14], obs[4][13]}, {30'd0, 1'b1, 1'b0});

        // Unsupported opcode: trap, sticky flag, no enables, no done
        do_instr("trap", 6'b111111, 32'hFFFF_FFFF, 1'b1, 8, 0, d);
        check("trap_no_done", 32'(d), 32'd0);
        check("trap_flag", 32'(obs[8][4]), 32'd1);
        check("trap_state", 32'(obs[8][3:0]), 32'd12);
        check("trap_no_enables", 32'(obs[8][21:5]), 32'd0);
        apply_reset(1'b1, v);
        check("trap_cleared", 32'(v[4]), 32'd0);

        // Reset while lw is stalled in MEM_READ
        do_instr("lw_rst", 6'b100011, 32'h0000_0007, 1'b1, 8, 5, d);
        check("stall_state", 32'(obs[4][3:0]), 32'd3);
        check("rst_midstall", {28'd0, obs[5][3:0] == 4'd0, obs[5][18], obs[5][19], obs[5][14]},
              {28'd0, 1'b1, 1'b1, 1'b0, 1'b0});

        // Random instruction stream with random memory stalls, occasional resets and traps
        for (int k = 0; k < 80; k++) begin
            int ab;
            ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 6)) : 0;
            if ($urandom_range(0, 14) == 0) begin
                do_instr("rnd_trap", 6'b110000 | 6'($urandom_range(0, 15)), 32'd0, 1'b0, 6, 0, d);
                apply_reset(logic'($urandom_range(0, 1)), v);
            end else begin
                do_instr("rnd", ops[$urandom_range(0, 5)], 32'd0, 1'b0, 64, ab, d);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
